loop_gain_scheduler: RTL

Gear-shifting controller for the ADPLL PI loop filter. It watches the signed phase/frequency error on each loop update and drives the filter's runtime gain inputs (kp_i/ki_i, used with DYNAMIC_VAL=1). It steps the gains through three gears: ACQUIRE (high gain), TRACK (medium) and LOCKED (low). It reports lock status and drops back to ACQUIRE when lock is lost.

---
 rtl/loop_gain_scheduler.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/loop_gain_scheduler.sv
// Gear-shifting gain scheduler for the ADPLL PI loop filter.
// Steps kp/ki through ACQUIRE, TRACK and LOCKED from error statistics.
module loop_gain_scheduler #(
  parameter int ERROR_WIDTH = 8,
  parameter int KP_WIDTH = 3,
  parameter int KI_WIDTH = 4,
  parameter logic [KP_WIDTH-1:0] KP_ACQ = 3'b100,
  parameter logic [KI_WIDTH-1:0] KI_ACQ = 4'b0100,
  parameter logic [KP_WIDTH-1:0] KP_TRK = 3'b010,
  parameter logic [KI_WIDTH-1:0] KI_TRK = 4'b0010,
  parameter logic [KP_WIDTH-1:0] KP_LCK = 3'b001,
  parameter logic [KI_WIDTH-1:0] KI_LCK = 4'b0001,
  parameter int LOCK_THRESH = 4,
  parameter int UNLOCK_THRESH = 16,
  parameter int LOCK_COUNT = 32,
  parameter int UNLOCK_COUNT = 4,
  parameter int CNT_WIDTH = 8
) (
  input  logic                   gen_clk_i,
  input  logic                   reset_n_i,
  input  logic                   error_valid_i,
  input  logic [ERROR_WIDTH-1:0] error_i,
  input  logic                   force_acq_i,
  output logic [KP_WIDTH-1:0]    kp_o,
  output logic [KI_WIDTH-1:0]    ki_o,
  output logic [1:0]             gear_o,
  output logic                   lock_o,
  output logic                   gain_update_o
);

  typedef enum logic [1:0] {
    GEAR_ACQ = 2'b00,
    GEAR_TRK = 2'b01,
    GEAR_LCK = 2'b10
  } gear_e;

  localparam logic [ERROR_WIDTH-1:0] ERR_MIN =
    {1'b1, {(ERROR_WIDTH-1){1'b0}}};
  localparam logic [ERROR_WIDTH-1:0] ERR_MAX =
    {1'b0, {(ERROR_WIDTH-1){1'b1}}};
  localparam logic [ERROR_WIDTH-1:0] LOCK_T =
    ERROR_WIDTH'(LOCK_THRESH);
  localparam logic [ERROR_WIDTH-1:0] UNLOCK_T =
    ERROR_WIDTH'(UNLOCK_THRESH);
  localparam logic [CNT_WIDTH-1:0] LOCK_MAX =
    CNT_WIDTH'(LOCK_COUNT);
  localparam logic [CNT_WIDTH-1:0] LOCK_LAST =
    CNT_WIDTH'(LOCK_COUNT - 1);
  localparam logic [CNT_WIDTH-1:0] UNLOCK_MAX =
    CNT_WIDTH'(UNLOCK_COUNT);
  localparam logic [CNT_WIDTH-1:0] UNLOCK_LAST =
    CNT_WIDTH'(UNLOCK_COUNT - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE =
    CNT_WIDTH'(1);

  gear_e gear_q, gear_d;
  logic [CNT_WIDTH-1:0] lock_cnt_q, lock_cnt_d;
  logic [CNT_WIDTH-1:0] unlock_cnt_q, unlock_cnt_d;
  logic [KP_WIDTH-1:0] kp_d;
  logic [KI_WIDTH-1:0] ki_d;
  logic lock_d, upd_d;

  logic [ERROR_WIDTH-1:0] abs_err;
  logic in_win, out_win;

  // Magnitude of the error; the most negative code saturates
  always_comb begin
    abs_err = error_i;
    if (error_i == ERR_MIN) begin
      abs_err = ERR_MAX;
    end else if (error_i[ERROR_WIDTH-1]) begin
      abs_err = ~error_i + ERROR_WIDTH'(1);
    end
  end

  assign in_win = (abs_err <= LOCK_T);
  assign out_win = (abs_err > UNLOCK_T);

  // State, counters and registered outputs
  always_ff @(posedge gen_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      gear_q <= GEAR_ACQ;
      lock_cnt_q <= '0;
      unlock_cnt_q <= '0;
      kp_o <= KP_ACQ;
      ki_o <= KI_ACQ;
      lock_o <= 1'b0;
      gain_update_o <= 1'b0;
    end else begin
      gear_q <= gear_d;
      lock_cnt_q <= lock_cnt_d;
      unlock_cnt_q <= unlock_cnt_d;
      kp_o <= kp_d;
      ki_o <= ki_d;
      lock_o <= lock_d;
      gain_update_o <= upd_d;
    end
  end

  // Next gear and counters from the current sample
  always_comb begin
    gear_d = gear_q;
    lock_cnt_d = lock_cnt_q;
    unlock_cnt_d = unlock_cnt_q;
    if (force_acq_i) begin
      gear_d = GEAR_ACQ;
      lock_cnt_d = '0;
      unlock_cnt_d = '0;
    end else if (error_valid_i) begin
      if (!in_win) begin
        lock_cnt_d = '0;
      end else if (lock_cnt_q != LOCK_MAX) begin
        lock_cnt_d = lock_cnt_q + CNT_ONE;
      end
      if (gear_q == GEAR_ACQ || in_win) begin
        unlock_cnt_d = '0;
      end else if (out_win && unlock_cnt_q != UNLOCK_MAX) begin
        unlock_cnt_d = unlock_cnt_q + CNT_ONE;
      end
      if (in_win && gear_q != GEAR_LCK
          && lock_cnt_q == LOCK_LAST) begin
        gear_d = (gear_q == GEAR_ACQ) ? GEAR_TRK : GEAR_LCK;
        lock_cnt_d = '0;
      end
      if (out_win && gear_q != GEAR_ACQ
          && unlock_cnt_q == UNLOCK_LAST) begin
        gear_d = GEAR_ACQ;
        lock_cnt_d = '0;
        unlock_cnt_d = '0;
      end
    end
  end

  // Gains, lock flag and update pulse for the next gear
  always_comb begin
    kp_d = KP_ACQ;
    ki_d = KI_ACQ;
    lock_d = 1'b0;
    upd_d = (gear_d != gear_q);
    unique case (gear_d)
      GEAR_TRK: begin
        kp_d = KP_TRK;
        ki_d = KI_TRK;
      end
      GEAR_LCK: begin
        kp_d = KP_LCK;
        ki_d = KI_LCK;
        lock_d = 1'b1;
      end
      default: begin
        kp_d = KP_ACQ;
        ki_d = KI_ACQ;
      end
    endcase
  end

  assign gear_o = gear_q;

endmodule
